// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, stall lengths and the source-register match helper.
package hazard_pkg;

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      STALL    = 2'd2,
      MEM_WAIT = 2'd3
   } state_e;

   localparam logic [1:0] LU_STALL = 2'd1;
   localparam logic [1:0] LB_STALL = 2'd2;
   localparam logic [4:0] REG_ZERO = 5'd0;

   // $zero is hardwired, so a write to it never creates a dependency
   function automatic logic src_match(input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt,
                                      input logic [4:0] wreg);
      return (wreg != REG_ZERO) && ((rs == wreg) || (uses_rt && (rt == wreg)));
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection: matches the ID sources against the EX/MEM
// destinations and reports the stall length required (0, 1 or 2 cycles).
module hazard_detect
   import hazard_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       id_branch,
   input  logic       ex_memread,
   input  logic       ex_regwrite,
   input  logic [4:0] ex_wreg,
   input  logic       mem_memread,
   input  logic [4:0] mem_wreg,
   output logic [1:0] stall_len
);

   logic ex_match;
   logic mem_match;

   assign ex_match  = src_match(id_rs, id_rt, id_uses_rt, ex_wreg);
   assign mem_match = src_match(id_rs, id_rt, id_uses_rt, mem_wreg);

   // Branches compare in ID, so they need operands one stage earlier than ALU ops
   always_comb begin
      stall_len = '0;
      if (ex_memread && ex_match) begin
         stall_len = id_branch ? LB_STALL : LU_STALL;
      end else if (id_branch && ((ex_regwrite && ex_match) || (mem_memread && mem_match))) begin
         stall_len = LU_STALL;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and memory-wait freezes for the
// 5-stage core. Define HAZARD_STATS_EN to add the stall/flush statistics counters.
module hazard_ctrl
   import hazard_pkg::*;
`ifdef HAZARD_STATS_EN
#(
   parameter int unsigned CNT_W = 32
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       id_branch,
   input  logic       id_jump,
   input  logic       branch_taken,
   input  logic       ex_memread,
   input  logic       ex_regwrite,
   input  logic [4:0] ex_wreg,
   input  logic       mem_memread,
   input  logic [4:0] mem_wreg,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ifid_write,
   output logic       ifflush,
   output logic       idex_bubble,
   output logic       pipe_hold
`ifdef HAZARD_STATS_EN
  ,output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   state_e     state_q, state_d;
   state_e     ret_q, ret_d;
   logic [1:0] scnt_q, scnt_d;
   logic [1:0] stall_len;
   logic       mem_wait;

   hazard_detect u_detect (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .id_branch   (id_branch),
      .ex_memread  (ex_memread),
      .ex_regwrite (ex_regwrite),
      .ex_wreg     (ex_wreg),
      .mem_memread (mem_memread),
      .mem_wreg    (mem_wreg),
      .stall_len   (stall_len)
   );

   assign mem_wait = mem_req && !mem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         ret_q   <= RUN;
         scnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         scnt_q  <= scnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      scnt_d      = scnt_q;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifflush     = 1'b0;
      idex_bubble = 1'b0;
      pipe_hold   = 1'b0;
      unique case (state_q)
         INIT: begin
            ifflush     = 1'b1;
            idex_bubble = 1'b1;
            state_d     = RUN;
         end
         RUN: begin
            if (mem_wait) begin
               // Entry cycle keeps normal enables; the freeze starts in MEM_WAIT
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ret_d      = RUN;
               state_d    = MEM_WAIT;
            end else if (stall_len != 2'd0) begin
               idex_bubble = 1'b1;
               scnt_d      = stall_len - 2'd1;
               if (stall_len > 2'd1) state_d = STALL;
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ifflush    = id_jump || (id_branch && branch_taken);
            end
         end
         STALL: begin
            idex_bubble = 1'b1;
            if (mem_wait) begin
               ret_d   = STALL;
               state_d = MEM_WAIT;
            end else begin
               scnt_d = (scnt_q != 2'd0) ? scnt_q - 2'd1 : 2'd0;
               if (scnt_q <= 2'd1) state_d = RUN;
            end
         end
         MEM_WAIT: begin
            pipe_hold = 1'b1;
            if (mem_ready) state_d = ret_q;
         end
         default: begin
            ifflush     = 1'b1;
            idex_bubble = 1'b1;
            state_d     = INIT;
         end
      endcase
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (idex_bubble && (state_q == RUN || state_q == STALL) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (ifflush && (state_q == RUN) && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; output vector order is
// {pc_write, ifid_write, ifflush, idex_bubble, pipe_hold}.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
   logic       id_uses_rt, id_branch, id_jump, branch_taken;
   logic       ex_memread, ex_regwrite, mem_memread, mem_req, mem_ready;
   logic       pc_write, ifid_write, ifflush, idex_bubble, pipe_hold;
   logic [4:0] outs;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [4:0] O_RST   = 5'b00110;
   localparam logic [4:0] O_RUN   = 5'b11000;
   localparam logic [4:0] O_FLUSH = 5'b11100;
   localparam logic [4:0] O_STALL = 5'b00010;
   localparam logic [4:0] O_WAIT  = 5'b00001;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .id_branch    (id_branch),
      .id_jump      (id_jump),
      .branch_taken (branch_taken),
      .ex_memread   (ex_memread),
      .ex_regwrite  (ex_regwrite),
      .ex_wreg      (ex_wreg),
      .mem_memread  (mem_memread),
      .mem_wreg     (mem_wreg),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifflush      (ifflush),
      .idex_bubble  (idex_bubble),
      .pipe_hold    (pipe_hold)
`ifdef HAZARD_STATS_EN
     ,.stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   assign outs = {pc_write, ifid_write, ifflush, idex_bubble, pipe_hold};

   task automatic idle();
      id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_branch = 1'b0; id_jump = 1'b0;
      branch_taken = 1'b0; ex_memread = 1'b0; ex_regwrite = 1'b0; ex_wreg = '0;
      mem_memread = 1'b0; mem_wreg = '0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (outs !== O_RST) begin n_err++; $display("FAIL rst_hold%0d: got %b want %b", i, outs, O_RST); end
         @(posedge clk);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (outs !== O_RST) begin n_err++; $display("FAIL init_cycle: got %b want %b", outs, O_RST); end
      next_cycle();
      @(negedge clk);
      n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL first_run: got %b want %b", outs, O_RUN); end
      next_cycle();
   endtask

   task automatic test_jump();
      idle(); id_jump = 1'b1;
      @(negedge clk);
      n_cmp++; if (outs !== O_FLUSH) begin n_err++; $display("FAIL jump_flush: got %b want %b", outs, O_FLUSH); end
      next_cycle();
      idle();
      @(negedge clk);
      n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL jump_after: got %b want %b", outs, O_RUN); end
`ifdef HAZARD_STATS_EN
      n_cmp++; if (flush_cnt !== 32'd1) begin n_err++; $display("FAIL flush_cnt: got %0d want 1", flush_cnt); end
      n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL stall_cnt0: got %0d want 0", stall_cnt); end
`endif
      next_cycle();
   endtask

   task automatic test_load_use();
      idle(); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8;
      @(negedge clk);
      n_cmp++; if (outs !== O_STALL) begin n_err++; $display("FAIL lu_stall: got %b want %b", outs, O_STALL); end
      next_cycle();
      ex_memread = 1'b0; ex_regwrite = 1'b0; ex_wreg = '0; mem_memread = 1'b1; mem_wreg = 5'd8;
      @(negedge clk);
      n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL lu_resume: got %b want %b", outs, O_RUN); end
      next_cycle();
      idle(); ex_memread = 1'b1; ex_wreg = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
      @(negedge clk);
      n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL lu_rt_unused: got %b want %b", outs, O_RUN); end
      next_cycle();
      id_uses_rt = 1'b1;
      @(negedge clk);
      n_cmp++; if (outs !== O_STALL) begin n_err++; $display("FAIL lu_rt_used: got %b want %b", outs, O_STALL); end
      next_cycle();
      idle();
      @(negedge clk);
      n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL lu_rt_resume: got %b want %b", outs, O_RUN); end
      next_cycle();
   endtask

   task automatic test_branch();
      idle(); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8; id_branch = 1'b1; id_rs = 5'd8;
      @(negedge clk);
      n_cmp++; if (outs !== O_STALL) begin n_err++; $display("FAIL lb_stall1: got %b want %b", outs, O_STALL); end
      next_cycle();
      ex_memread = 1'b0; ex_regwrite = 1'b0; ex_wreg = '0; mem_memread = 1'b1; mem_wreg = 5'd8;
      @(negedge clk);
      n_cmp++; if (outs !== O_STALL) begin n_err++; $display("FAIL lb_stall2: got %b want %b", outs, O_STALL); end
      next_cycle();
      mem_memread = 1'b0; mem_wreg = '0; branch_taken = 1'b1;
      @(negedge clk);
      n_cmp++; if (outs !== O_FLUSH) begin n_err++; $display("FAIL lb_resolve: got %b want %b", outs, O_FLUSH); end
      next_cycle();
      idle(); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd0; id_branch = 1'b1; id_rs = 5'd0;
      @(negedge clk);
      n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL lb_reg_zero: got %b want %b", outs, O_RUN); end
      next_cycle();
      idle(); ex_regwrite = 1'b1; ex_wreg = 5'd9; id_branch = 1'b1; id_rs = 5'd2; id_rt = 5'd9; id_uses_rt = 1'b1;
      @(negedge clk);
      n_cmp++; if (outs !== O_STALL) begin n_err++; $display("FAIL alu_br_stall: got %b want %b", outs, O_STALL); end
      next_cycle();
      ex_regwrite = 1'b0; ex_wreg = '0; mem_wreg = 5'd9; branch_taken = 1'b1;
      @(negedge clk);
      n_cmp++; if (outs !== O_FLUSH) begin n_err++; $display("FAIL alu_br_resolve: got %b want %b", outs, O_FLUSH); end
      next_cycle();
      idle();
      @(negedge clk);
      n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL br_idle: got %b want %b", outs, O_RUN); end
      next_cycle();
   endtask

   task automatic test_mem_wait_stall();
      logic [4:0] exp_seq [8];
      exp_seq = '{O_STALL, O_STALL, O_WAIT, O_WAIT, O_WAIT, O_WAIT, O_STALL, O_FLUSH};
      for (int c = 0; c < 8; c++) begin
         idle();
         id_branch = 1'b1; id_rs = 5'd8;
         if (c == 0) begin ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8; end
         else if (c < 7) begin mem_memread = 1'b1; mem_wreg = 5'd8; end
         else branch_taken = 1'b1;
         mem_req   = (c >= 1 && c <= 5);
         mem_ready = (c == 5);
         @(negedge clk);
         n_cmp++; if (outs !== exp_seq[c]) begin n_err++; $display("FAIL memwait_stall c%0d: got %b want %b", c, outs, exp_seq[c]); end
         next_cycle();
      end
   endtask

   task automatic test_mem_wait_run();
      logic [4:0] exp_seq [6];
      exp_seq = '{O_RUN, O_RUN, O_RUN, O_WAIT, O_WAIT, O_FLUSH};
      for (int c = 0; c < 6; c++) begin
         idle();
         mem_req   = (c == 0) || (c >= 2 && c <= 4);
         mem_ready = (c == 0) || (c == 4);
         id_jump   = (c == 2) || (c == 5);
         @(negedge clk);
         n_cmp++; if (outs !== exp_seq[c]) begin n_err++; $display("FAIL memwait_run c%0d: got %b want %b", c, outs, exp_seq[c]); end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid_wait();
      idle(); mem_req = 1'b1;
      next_cycle();
      @(negedge clk);
      n_cmp++; if (outs !== O_WAIT) begin n_err++; $display("FAIL mid_wait_pre: got %b want %b", outs, O_WAIT); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (outs !== O_RST) begin n_err++; $display("FAIL mid_wait_rst: got %b want %b", outs, O_RST); end
`ifdef HAZARD_STATS_EN
      n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_err++; $display("FAIL cnt_clear: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
`endif
      next_cycle();
      @(negedge clk);
      n_cmp++; if (outs !== O_RST) begin n_err++; $display("FAIL mid_wait_hold: got %b want %b", outs, O_RST); end
      next_cycle();
      rst_n = 1'b1; mem_req = 1'b0;
      @(negedge clk);
      n_cmp++; if (outs !== O_RST) begin n_err++; $display("FAIL mid_wait_init: got %b want %b", outs, O_RST); end
      next_cycle();
      @(negedge clk);
      n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL mid_wait_run: got %b want %b", outs, O_RUN); end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_jump();
      test_load_use();
      test_branch();
      test_mem_wait_stall();
      test_mem_wait_run();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
